// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: PRBS7 defaults, checker state encoding and the LFSR step helper.
package serdes_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StCheck
    } chk_state_t;

    localparam int unsigned PrbsOrder = 7;
    localparam int unsigned PrbsTap   = 6;

    // Fibonacci step toward the MSB; callers narrow the result to their own ORDER (<= 32).
    function automatic logic [31:0] prbs_next(input logic [31:0] lfsr, input logic shift_bit);
        return {lfsr[30:0], shift_bit};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; clear wins over increment.
module sat_counter #(
    parameter int unsigned CntW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic [CntW-1:0] count_o
);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-seeding PRBS checker with BER counters and lock monitor.
// Optional PRBS_CHK_SNAPSHOT_EN adds err_snap/bit_snap captured on clr_counts.
module prbs_checker
    import serdes_pkg::*;
#(
    parameter int unsigned ORDER       = PrbsOrder,
    parameter int unsigned TAP         = PrbsTap,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             data_in,
    input  logic             data_in_valid,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
`ifdef PRBS_CHK_SNAPSHOT_EN
    output logic [CNT_W-1:0] err_snap,
    output logic [CNT_W-1:0] bit_snap,
`endif
    output logic             lock_lost
);

    localparam int unsigned SeedW   = $clog2(ORDER + 1);
    localparam int unsigned WinBitW = $clog2(WINDOW + 1);
    localparam int unsigned WinErrW = $clog2(LOSS_THRESH + 1);
    localparam logic [SeedW-1:0]   SeedLast = SeedW'(ORDER - 1);
    localparam logic [WinBitW-1:0] WinLast  = WinBitW'(WINDOW - 1);
    localparam logic [WinErrW-1:0] WinLoss  = WinErrW'(LOSS_THRESH);

    chk_state_t         state_q, state_d;
    logic [ORDER-1:0]   lfsr_q, lfsr_d;
    logic [SeedW-1:0]   seed_cnt_q, seed_cnt_d;
    logic [WinBitW-1:0] win_bits_q, win_bits_d;
    logic [WinErrW-1:0] win_err_q, win_err_d, win_err_inc;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               lock_lost_q, lock_lost_d;
    logic               predicted, mismatch;
    logic               err_inc, bit_inc, lost_set;

    assign predicted   = lfsr_q[ORDER-1] ^ lfsr_q[TAP-1];
    assign mismatch    = data_in ^ predicted;
    assign win_err_inc = win_err_q + WinErrW'(mismatch);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seed_cnt_d = seed_cnt_q;
        win_bits_d = win_bits_q;
        win_err_d  = win_err_q;
        err_inc    = 1'b0;
        bit_inc    = 1'b0;
        lost_set   = 1'b0;

        if (!en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StSeed;
                    seed_cnt_d = '0;
                end
                StSeed: begin
                    if (data_in_valid) begin
                        lfsr_d = ORDER'(prbs_next(32'(lfsr_q), data_in));
                        if (seed_cnt_q == SeedLast) begin
                            seed_cnt_d = '0;
                            // An all-zero register is the LFSR lock-up state; keep seeding.
                            if (lfsr_d != '0) begin
                                state_d    = StCheck;
                                win_bits_d = '0;
                                win_err_d  = '0;
                            end
                        end else begin
                            seed_cnt_d = seed_cnt_q + SeedW'(1);
                        end
                    end
                end
                StCheck: begin
                    if (data_in_valid) begin
                        // Self-prediction keeps one flipped input bit from costing more errors.
                        lfsr_d  = ORDER'(prbs_next(32'(lfsr_q), predicted));
                        bit_inc = 1'b1;
                        err_inc = mismatch;
                        if (win_err_inc >= WinLoss) begin
                            state_d    = StSeed;
                            seed_cnt_d = '0;
                            win_bits_d = '0;
                            win_err_d  = '0;
                            lost_set   = 1'b1;
                        end else if (win_bits_q == WinLast) begin
                            win_bits_d = '0;
                            win_err_d  = '0;
                        end else begin
                            win_bits_d = win_bits_q + WinBitW'(1);
                            win_err_d  = win_err_inc;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        locked_d    = (state_d == StCheck);
        err_pulse_d = err_inc;
        lock_lost_d = clr_counts ? 1'b0 : (lock_lost_q | lost_set);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            lfsr_q      <= '0;
            seed_cnt_q  <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_cnt_q  <= seed_cnt_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    sat_counter #(.CntW(CNT_W)) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rstn),
        .inc_i  (err_inc),
        .clr_i  (clr_counts),
        .count_o(err_count)
    );

    sat_counter #(.CntW(CNT_W)) u_bit_cnt (
        .clk_i  (clk),
        .rst_ni (rstn),
        .inc_i  (bit_inc),
        .clr_i  (clr_counts),
        .count_o(bit_count)
    );

`ifdef PRBS_CHK_SNAPSHOT_EN
    logic [CNT_W-1:0] err_snap_q, err_snap_d, bit_snap_q, bit_snap_d;

    // Capture includes this cycle's increment so the host sees a gap-free interval.
    always_comb begin
        err_snap_d = err_snap_q;
        bit_snap_d = bit_snap_q;
        if (clr_counts) begin
            err_snap_d = (err_inc && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;
            bit_snap_d = (bit_inc && (bit_count != '1)) ? bit_count + CNT_W'(1) : bit_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_snap_q <= '0;
            bit_snap_q <= '0;
        end else begin
            err_snap_q <= err_snap_d;
            bit_snap_q <= bit_snap_d;
        end
    end

    assign err_snap = err_snap_q;
    assign bit_snap = bit_snap_q;
`else
    // Snapshot registers are absent in this build.
`endif

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;

endmodule
